// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//  Bundle of the write-back arbiter's bus signals.
//  Source A : a_valid/a_addr/a_data in, a_ready out   (ALU results, priority)
//  Source B : b_valid/b_addr/b_data in, b_ready out   (load/multi-cycle, FIFO)
//  Regfile  : wa3/wd3/we3 out                         (registered write port)
//  Hazard   : busy_mask out (bit n = write to Xn pending), fifo_count out
//  slave  modport : arbiter side
//  master modport : producer / consumer side
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int W  = 64,
   parameter int AW = 5
);
   logic          a_valid;
   logic          a_ready;
   logic [AW-1:0] a_addr;
   logic [W-1:0]  a_data;

   logic          b_valid;
   logic          b_ready;
   logic [AW-1:0] b_addr;
   logic [W-1:0]  b_data;

   logic [AW-1:0] wa3;
   logic [W-1:0]  wd3;
   logic          we3;

   logic [31:0]   busy_mask;
   logic [AW:0]   fifo_count;

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready,
      output wa3, wd3, we3,
      output busy_mask, fifo_count
   );

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready,
      input  wa3, wd3, we3,
      input  busy_mask, fifo_count
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//  Merges ALU results (source A) and buffered load results (source B) onto
//  the single 64-bit register file write port.
//  Ports:
//   clk    : clock, posedge
//   reset  : asynchronous, active-low
//   bus    : regfile_wb_arbiter_if.slave (A/B handshakes, wa3/wd3/we3,
//            busy_mask, fifo_count)
//  Behaviour summary:
//   - A owns the write slot whenever its destination has no pending write.
//   - Otherwise the FIFO head (B) owns the slot.
//   - Writes to X31 are accepted and silently dropped.
//   - busy_mask covers every queued B entry plus the output stage, so a
//     younger A write never overtakes an older write to the same register.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   parameter int AW    = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int PW = $clog2(DEPTH) + 1;   // pointer width incl. wrap bit
   localparam int IW = PW - 1;              // storage index width
   localparam int CW = AW + 1;              // fifo_count width
   localparam logic [AW-1:0] XZR = '1;

   // FIFO storage and pointers
   logic [AW-1:0] mem_addr [DEPTH];
   logic [W-1:0]  mem_data [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, count;
   logic          full, empty;

   // output stage
   logic          we3_q;
   logic [AW-1:0] wa3_q;
   logic [W-1:0]  wd3_q;

   // arbitration
   logic          a_x31, b_x31;
   logic          a_elig, a_slot;
   logic          push, pop;
   logic [31:0]   fifo_busy, busy;
   logic [IW-1:0] scan_idx;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);

   // busy mask: every live FIFO entry plus the write currently on the port.
   // Bit 31 is masked off as a safety net; X31 never enters either source.
   always_comb begin
      fifo_busy = '0;
      scan_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr[IW-1:0] + IW'(k);
         if (PW'(k) < count)
            fifo_busy = fifo_busy | (32'd1 << mem_addr[scan_idx]);
      end
      busy = fifo_busy;
      if (we3_q)
         busy = busy | (32'd1 << wa3_q);
      busy[31] = 1'b0;
   end

   assign a_x31  = (bus.a_addr == XZR);
   assign b_x31  = (bus.b_addr == XZR);
   assign a_elig = bus.a_valid && !busy[bus.a_addr];
   // an X31 A write is accepted but leaves the slot free for the FIFO
   assign a_slot = a_elig && !a_x31;
   assign pop    = !a_slot && !empty;
   assign push   = bus.b_valid && !full && !b_x31;

   assign bus.a_ready    = a_elig;
   assign bus.b_ready    = !full;
   assign bus.busy_mask  = busy;
   assign bus.fifo_count = CW'(count);
   assign bus.we3        = we3_q;
   assign bus.wa3        = wa3_q;
   assign bus.wd3        = wd3_q;

   // pointers: same-cycle push and pop both advance, count unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage needs no reset; liveness is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr[IW-1:0]] <= bus.b_addr;
         mem_data[wr_ptr[IW-1:0]] <= bus.b_data;
      end
   end

   // output stage: one-cycle write pulse; addr/data hold when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we3_q <= 1'b0;
         wa3_q <= '0;
         wd3_q <= '0;
      end else begin
         we3_q <= a_slot || pop;
         if (a_slot) begin
            wa3_q <= bus.a_addr;
            wd3_q <= bus.a_data;
         end else if (pop) begin
            wa3_q <= mem_addr[rd_ptr[IW-1:0]];
            wd3_q <= mem_data[rd_ptr[IW-1:0]];
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//  Directed bench for the register-file write-back arbiter. Inputs change
//  1 time unit after the rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
   logic clk;
   logic rst_n;
   int   vecs;
   int   errs;

   regfile_wb_arbiter_if #(.W(64), .AW(5)) bus ();

   regfile_wb_arbiter #(.DEPTH(4), .W(64), .AW(5)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL rst_we3: got %0h want 0", bus.we3); end
      vecs++; if (bus.wa3 !== 5'd0) begin errs++; $display("FAIL rst_wa3: got %0h want 0", bus.wa3); end
      vecs++; if (bus.wd3 !== 64'd0) begin errs++; $display("FAIL rst_wd3: got %0h want 0", bus.wd3); end
      vecs++; if (bus.fifo_count !== 6'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
      vecs++; if (bus.busy_mask !== 32'd0) begin errs++; $display("FAIL rst_busy: got %h want 0", bus.busy_mask); end
      tick();
      rst_n = 1'b1;
      tick();
      vecs++; if (bus.b_ready !== 1'b1) begin errs++; $display("FAIL rst_bready: got %0h want 1", bus.b_ready); end
   endtask

   task automatic test_a_single();
      bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'h1234;
      #1;
      vecs++; if (bus.a_ready !== 1'b1) begin errs++; $display("FAIL a1_ready: got %0h want 1", bus.a_ready); end
      tick();
      bus.a_valid = 1'b0;
      vecs++; if (bus.we3 !== 1'b1) begin errs++; $display("FAIL a1_we3: got %0h want 1", bus.we3); end
      vecs++; if (bus.wa3 !== 5'd5) begin errs++; $display("FAIL a1_wa3: got %0d want 5", bus.wa3); end
      vecs++; if (bus.wd3 !== 64'h1234) begin errs++; $display("FAIL a1_wd3: got %h want 1234", bus.wd3); end
      vecs++; if (bus.busy_mask !== 32'h20) begin errs++; $display("FAIL a1_busy: got %h want 20", bus.busy_mask); end
      tick();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL a1_we3_off: got %0h want 0", bus.we3); end
      vecs++; if (bus.busy_mask !== 32'd0) begin errs++; $display("FAIL a1_busy_off: got %h want 0", bus.busy_mask); end
   endtask

   task automatic test_x31();
      bus.a_valid = 1'b1; bus.a_addr = 5'd31; bus.a_data = 64'hDEAD;
      bus.b_valid = 1'b1; bus.b_addr = 5'd31; bus.b_data = 64'hBEEF;
      #1;
      vecs++; if (bus.a_ready !== 1'b1) begin errs++; $display("FAIL x31_aready: got %0h want 1", bus.a_ready); end
      vecs++; if (bus.b_ready !== 1'b1) begin errs++; $display("FAIL x31_bready: got %0h want 1", bus.b_ready); end
      tick();
      idle_inputs();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL x31_we3: got %0h want 0", bus.we3); end
      vecs++; if (bus.busy_mask !== 32'd0) begin errs++; $display("FAIL x31_busy: got %h want 0", bus.busy_mask); end
      vecs++; if (bus.fifo_count !== 6'd0) begin errs++; $display("FAIL x31_count: got %0d want 0", bus.fifo_count); end
      tick();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL x31_we3_2: got %0h want 0", bus.we3); end
   endtask

   // A alternates X10/X11 to hold the slot every cycle while B fills the FIFO
   task automatic test_fifo_order();
      for (int i = 0; i < 4; i++) begin
         bus.a_valid = 1'b1; bus.a_addr = 5'd10 + 5'(i % 2); bus.a_data = 64'(i);
         bus.b_valid = 1'b1; bus.b_addr = 5'(i + 1);         bus.b_data = 64'h100 + 64'(i + 1);
         #1;
         vecs++; if (bus.b_ready !== 1'b1) begin errs++; $display("FAIL fo_bready%0d: got %0h want 1", i, bus.b_ready); end
         tick();
      end
      idle_inputs();
      #1;
      vecs++; if (bus.fifo_count !== 6'd4) begin errs++; $display("FAIL fo_count_full: got %0d want 4", bus.fifo_count); end
      vecs++; if (bus.b_ready !== 1'b0) begin errs++; $display("FAIL fo_bready_full: got %0h want 0", bus.b_ready); end
      vecs++; if (bus.busy_mask !== 32'h81E) begin errs++; $display("FAIL fo_busy: got %h want 81e", bus.busy_mask); end
      for (int i = 0; i < 4; i++) begin
         tick();
         vecs++; if (bus.we3 !== 1'b1) begin errs++; $display("FAIL fo_we3_%0d: got %0h want 1", i, bus.we3); end
         vecs++; if (bus.wa3 !== 5'(i + 1)) begin errs++; $display("FAIL fo_wa3_%0d: got %0d want %0d", i, bus.wa3, i + 1); end
         vecs++; if (bus.wd3 !== 64'h100 + 64'(i + 1)) begin errs++; $display("FAIL fo_wd3_%0d: got %h want %h", i, bus.wd3, 64'h100 + 64'(i + 1)); end
         vecs++; if (bus.fifo_count !== 6'(3 - i)) begin errs++; $display("FAIL fo_count_%0d: got %0d want %0d", i, bus.fifo_count, 3 - i); end
      end
      tick();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL fo_we3_end: got %0h want 0", bus.we3); end
   endtask

   task automatic test_hazard();
      bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'hAA;
      tick();
      bus.b_valid = 1'b0;
      bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 64'hBB;
      #1;
      vecs++; if (bus.a_ready !== 1'b0) begin errs++; $display("FAIL hz_aready_q: got %0h want 0", bus.a_ready); end
      tick();
      vecs++; if (bus.we3 !== 1'b1) begin errs++; $display("FAIL hz_we3_b: got %0h want 1", bus.we3); end
      vecs++; if (bus.wd3 !== 64'hAA) begin errs++; $display("FAIL hz_wd3_b: got %h want aa", bus.wd3); end
      vecs++; if (bus.a_ready !== 1'b0) begin errs++; $display("FAIL hz_aready_o: got %0h want 0", bus.a_ready); end
      tick();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL hz_we3_gap: got %0h want 0", bus.we3); end
      vecs++; if (bus.a_ready !== 1'b1) begin errs++; $display("FAIL hz_aready_free: got %0h want 1", bus.a_ready); end
      tick();
      bus.a_valid = 1'b0;
      vecs++; if (bus.we3 !== 1'b1) begin errs++; $display("FAIL hz_we3_a: got %0h want 1", bus.we3); end
      vecs++; if (bus.wa3 !== 5'd7) begin errs++; $display("FAIL hz_wa3_a: got %0d want 7", bus.wa3); end
      vecs++; if (bus.wd3 !== 64'hBB) begin errs++; $display("FAIL hz_wd3_a: got %h want bb", bus.wd3); end
      tick();
   endtask

   // A alternates X2/X3 so it stays eligible every cycle; B X9 waits
   task automatic test_back_to_back();
      bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 64'h99;
      for (int i = 0; i < 3; i++) begin
         bus.a_valid = 1'b1; bus.a_addr = (i % 2 == 0) ? 5'd2 : 5'd3; bus.a_data = 64'h20 + 64'(i);
         tick();
         bus.b_valid = 1'b0;
         vecs++; if (bus.wa3 !== ((i % 2 == 0) ? 5'd2 : 5'd3)) begin errs++; $display("FAIL bb_wa3_%0d: got %0d want %0d", i, bus.wa3, (i % 2 == 0) ? 2 : 3); end
         vecs++; if (bus.wd3 !== 64'h20 + 64'(i)) begin errs++; $display("FAIL bb_wd3_%0d: got %h want %h", i, bus.wd3, 64'h20 + 64'(i)); end
         vecs++; if (bus.fifo_count !== 6'd1) begin errs++; $display("FAIL bb_count_%0d: got %0d want 1", i, bus.fifo_count); end
      end
      bus.a_valid = 1'b0;
      tick();
      vecs++; if (bus.we3 !== 1'b1) begin errs++; $display("FAIL bb_we3_b: got %0h want 1", bus.we3); end
      vecs++; if (bus.wa3 !== 5'd9) begin errs++; $display("FAIL bb_wa3_b: got %0d want 9", bus.wa3); end
      vecs++; if (bus.wd3 !== 64'h99) begin errs++; $display("FAIL bb_wd3_b: got %h want 99", bus.wd3); end
      vecs++; if (bus.fifo_count !== 6'd0) begin errs++; $display("FAIL bb_count_b: got %0d want 0", bus.fifo_count); end
      tick();
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL bb_we3_end: got %0h want 0", bus.we3); end
   endtask

   task automatic test_midstream_reset();
      for (int i = 0; i < 3; i++) begin
         bus.a_valid = 1'b1; bus.a_addr = 5'd20 + 5'(i % 2); bus.a_data = 64'(i);
         bus.b_valid = 1'b1; bus.b_addr = 5'(i + 12);        bus.b_data = 64'h300 + 64'(i);
         tick();
      end
      idle_inputs();
      vecs++; if (bus.fifo_count !== 6'd3) begin errs++; $display("FAIL mr_count_pre: got %0d want 3", bus.fifo_count); end
      rst_n = 1'b0;
      #1;
      vecs++; if (bus.fifo_count !== 6'd0) begin errs++; $display("FAIL mr_count: got %0d want 0", bus.fifo_count); end
      vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL mr_we3: got %0h want 0", bus.we3); end
      vecs++; if (bus.wa3 !== 5'd0) begin errs++; $display("FAIL mr_wa3: got %0d want 0", bus.wa3); end
      vecs++; if (bus.busy_mask !== 32'd0) begin errs++; $display("FAIL mr_busy: got %h want 0", bus.busy_mask); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++; if (bus.we3 !== 1'b0) begin errs++; $display("FAIL mr_we3_post%0d: got %0h want 0", i, bus.we3); end
      end
      vecs++; if (bus.fifo_count !== 6'd0) begin errs++; $display("FAIL mr_count_post: got %0d want 0", bus.fifo_count); end
      vecs++; if (bus.b_ready !== 1'b1) begin errs++; $display("FAIL mr_bready_post: got %0h want 1", bus.b_ready); end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_a_single();
      test_x31();
      test_fifo_order();
      test_hazard();
      test_back_to_back();
      test_midstream_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
